// File: rtl/branch_seq_defs.sv
// branch_seq_defs: shared state encodings and PC width for the branch sequencer
package branch_seq_defs;
  localparam int PC_W = 32;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESOLVE   = 2'd1,
    WAIT_SLOT = 2'd2,
    REDIRECT  = 2'd3
  } state_t;
endpackage

// File: rtl/branch_stat_cnt.sv
// branch_stat_cnt: taken / not-taken / stall event counters (BRANCH_STATS_EN builds only)
module branch_stat_cnt (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inc_taken,
  input  logic        inc_not_taken,
  input  logic        inc_stall,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_not_taken,
  output logic [31:0] stat_stall
);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
      stat_stall     <= '0;
    end else begin
      stat_taken     <= stat_taken + 32'(inc_taken);
      stat_not_taken <= stat_not_taken + 32'(inc_not_taken);
      stat_stall     <= stat_stall + 32'(inc_stall);
    end
endmodule

// File: rtl/branch_seq.sv
// branch_seq: ID-stage branch resolve / delay-slot wait / IF redirect sequencer
// Optional counters via `define BRANCH_STATS_EN.
module branch_seq
  import branch_seq_defs::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            br_valid,
  input  logic            br_ops_ready,
  input  logic            br_take,
  input  logic            br_link,
  input  logic [PC_W-1:0] br_target,
  input  logic            slot_ok,
  input  logic            flush,
  input  logic            redirect_ready,
  output logic            id_stall,
  output logic            br_done,
  output logic            link_we,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_not_taken,
  output logic [31:0]     stat_stall
`endif
);
  state_t          state;
  logic            take_q, link_q;
  logic [PC_W-1:0] pc_q;
  logic            resolving, eval, nt_done, rd_done;
  always_comb begin
    resolving      = (state == IDLE) || (state == RESOLVE);
    eval           = resolving && br_valid && br_ops_ready;
    // take_q is always set in REDIRECT; gating on it keeps the latched verdict meaningful
    redirect_valid = !flush && (state == REDIRECT) && take_q;
    rd_done        = redirect_valid && redirect_ready;
    nt_done        = !flush && eval && !br_take;
    br_done        = nt_done || rd_done;
    link_we        = (nt_done && br_link) || (rd_done && link_q);
    id_stall       = !flush && ((resolving && br_valid && (!br_ops_ready || br_take))
                               || (state == WAIT_SLOT)
                               || ((state == REDIRECT) && !redirect_ready));
    redirect_pc    = pc_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state  <= IDLE;
      take_q <= 1'b0;
      link_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      if (eval && !flush) begin
        take_q <= br_take;
        link_q <= br_link;
        pc_q   <= br_target;
      end
      if (flush) state <= IDLE;
      else
        case (state)
          IDLE, RESOLVE: state <= eval ? (br_take ? (slot_ok ? REDIRECT : WAIT_SLOT) : IDLE)
                                       : (br_valid ? RESOLVE : IDLE);
          WAIT_SLOT:     state <= slot_ok ? REDIRECT : WAIT_SLOT;
          REDIRECT:      state <= redirect_ready ? IDLE : REDIRECT;
          default:       state <= IDLE;
        endcase
    end
`ifdef BRANCH_STATS_EN
  branch_stat_cnt u_stat (
    .clk           (clk),
    .resetn        (resetn),
    .inc_taken     (rd_done),
    .inc_not_taken (nt_done),
    .inc_stall     (id_stall),
    .stat_taken    (stat_taken),
    .stat_not_taken(stat_not_taken),
    .stat_stall    (stat_stall)
  );
`endif
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: randomized transaction-level check of branch_seq
module tb_branch_seq;
  logic        clk = 0, resetn = 0;
  logic        br_valid = 0, br_ops_ready = 0, br_take = 0, br_link = 0;
  logic [31:0] br_target = 0;
  logic        slot_ok = 0, flush = 0, redirect_ready = 0;
  logic        id_stall, br_done, link_we, redirect_valid;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken, stat_not_taken, stat_stall;
`endif
  int n_chk = 0, n_fail = 0;
  int e_tk = 0, e_nt = 0, e_st = 0;

  branch_seq dut (
    .clk(clk), .resetn(resetn), .br_valid(br_valid), .br_ops_ready(br_ops_ready),
    .br_take(br_take), .br_link(br_link), .br_target(br_target), .slot_ok(slot_ok),
    .flush(flush), .redirect_ready(redirect_ready), .id_stall(id_stall),
    .br_done(br_done), .link_we(link_we), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit bv, input bit op, input bit tk, input bit lk,
                       input logic [31:0] tg, input bit so, input bit rr, input bit fl);
    @(negedge clk);
    br_valid = bv; br_ops_ready = op; br_take = tk; br_link = lk;
    br_target = tg; slot_ok = so; redirect_ready = rr; flush = fl;
    #1;
  endtask

  task automatic expect_o(input bit st, input bit dn, input bit lw, input bit rv,
                          input logic [31:0] pc, input bit tk);
    check("id_stall", 32'(id_stall), 32'(st));
    check("br_done", 32'(br_done), 32'(dn));
    check("link_we", 32'(link_we), 32'(lw));
    check("redirect_valid", 32'(redirect_valid), 32'(rv));
    if (rv) check("redirect_pc", redirect_pc, pc);
    e_st += int'(st);
    if (dn) begin
      if (tk) e_tk++;
      else e_nt++;
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // One branch as a script: ow operand-wait cycles, E, sw cycles without the slot
  // (counting from E), rw cycles of IF refusing the redirect. fl = cycle index of a flush.
  task automatic run_br(input int ow, input bit take, input bit link, input logic [31:0] tgt,
                        input int sw, input int rw, input int fl, input bit abandon);
    int c = 0;
    for (int i = 0; i < ow; i++) begin
      drive(1, 0, rb(), rb(), $urandom, rb(), rb(), c == fl);
      if (c == fl) begin expect_o(0, 0, 0, 0, 0, 0); return; end
      expect_o(1, 0, 0, 0, 0, 0);
      c++;
    end
    if (abandon) begin
      drive(0, rb(), rb(), rb(), $urandom, rb(), rb(), c == fl);
      expect_o(0, 0, 0, 0, 0, 0);
      return;
    end
    drive(1, 1, take, link, tgt, sw == 0, rb(), c == fl);
    if (c == fl) begin expect_o(0, 0, 0, 0, 0, 0); return; end
    if (!take) begin expect_o(0, 1, link, 0, 0, 0); return; end
    expect_o(1, 0, 0, 0, 0, 0);
    c++;
    for (int i = 1; i <= sw; i++) begin
      drive(1, 1, rb(), rb(), $urandom, i == sw, rb(), c == fl);
      if (c == fl) begin expect_o(0, 0, 0, 0, 0, 0); return; end
      expect_o(1, 0, 0, 0, 0, 0);
      c++;
    end
    for (int i = 0; i <= rw; i++) begin
      drive(1, 1, rb(), rb(), $urandom, rb(), i == rw, c == fl);
      if (c == fl) begin expect_o(0, 0, 0, 0, 0, 0); return; end
      expect_o(i != rw, i == rw, (i == rw) && link, 1, tgt, 1);
      c++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    expect_o(0, 0, 0, 0, 0, 0);
    check("reset_pc", redirect_pc, 32'h0);
    resetn = 1;
    run_br(0, 0, 0, 32'h1000, 0, 0, -1, 0);
    run_br(2, 1, 0, 32'hBFC00100, 0, 0, -1, 0);
    run_br(0, 1, 0, 32'h8000_0040, 2, 3, -1, 0);
    run_br(0, 0, 1, 32'h2222, 0, 0, -1, 0);
    run_br(0, 1, 1, 32'h3333, 0, 0, 1, 0);
    run_br(1, 0, 0, 32'h4444, 0, 0, -1, 1);
    run_br(0, 1, 1, 32'h5555, 1, 1, -1, 0);
    for (int n = 0; n < 200; n++) begin
      run_br($urandom_range(0, 3), rb(), rb(), $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1,
             $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        drive(0, rb(), rb(), rb(), $urandom, rb(), rb(), 0);
        expect_o(0, 0, 0, 0, 0, 0);
      end
    end
    drive(1, 1, 1, 0, 32'h7777, 0, 0, 0);
    expect_o(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 32'h0, 0, 0, 0);
    expect_o(1, 0, 0, 0, 0, 0);
    #2;
    resetn = 0;
    br_valid = 0;
    #1;
    expect_o(0, 0, 0, 0, 0, 0);
    check("async_rst_pc", redirect_pc, 32'h0);
    e_tk = 0; e_nt = 0; e_st = 0;
    @(negedge clk);
    resetn = 1;
    run_br(1, 1, 0, 32'h9999, 1, 1, -1, 0);
    run_br(0, 0, 0, 32'h1, 0, 0, -1, 0);
    run_br(0, 1, 0, 32'h2, 0, 2, 2, 0);
`ifdef BRANCH_STATS_EN
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("stat_taken", stat_taken, 32'(e_tk));
    check("stat_not_taken", stat_not_taken, 32'(e_nt));
    check("stat_stall", stat_stall, 32'(e_st));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
